// File: rtl/swap_xbar.sv
// swap_xbar: register bank with external load and FSM-driven swap/copy.
// Any two registers are exchanged through a hidden temp register or copied.
module swap_xbar #(
    parameter int WIDTH = 8,
    parameter int NREGS = 4,
    localparam int SW = $clog2(NREGS)
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic [WIDTH-1:0]       Data,
    input  logic                   Extern,
    input  logic [NREGS-1:0]       RinExt,
    input  logic                   w,
    input  logic                   Mode,
    input  logic [SW-1:0]          SelA,
    input  logic [SW-1:0]          SelB,
    output logic [WIDTH-1:0]       BusWires,
    output logic [NREGS*WIDTH-1:0] RegOut,
    output logic                   Busy,
    output logic                   Done
);

    typedef enum logic [2:0] {
        IDLE,
        S1,
        S2,
        S3,
        C1
    } state_t;

    localparam logic [SW:0] NR = (SW+1)'(NREGS);

    state_t           state;
    logic [SW-1:0]    sel_a;
    logic [SW-1:0]    sel_b;
    logic [WIDTH-1:0] tmp;
    logic [WIDTH-1:0] r [NREGS];
    logic             sel_ok;

    // A request is accepted only when both indices name a real register
    always_comb begin
        sel_ok = ({1'b0, SelA} < NR) && ({1'b0, SelB} < NR);
    end

    // Control FSM: latches operands on start, Busy/Done registered with state
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            sel_a <= '0;
            sel_b <= '0;
            Busy  <= 1'b0;
            Done  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (w && sel_ok) begin
                        sel_a <= SelA;
                        sel_b <= SelB;
                        state <= Mode ? C1 : S1;
                        Busy  <= 1'b1;
                        Done  <= Mode;
                    end
                end
                S1: begin
                    state <= S2;
                    Done  <= 1'b0;
                end
                S2: begin
                    state <= S3;
                    Done  <= 1'b1;
                end
                S3, C1: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                    Done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                    Done  <= 1'b0;
                end
            endcase
        end
    end

    // Register bank and temp: external loads in IDLE, transfers otherwise
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            tmp <= '0;
            for (int i = 0; i < NREGS; i++) begin
                r[i] <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (Extern) begin
                        for (int i = 0; i < NREGS; i++) begin
                            if (RinExt[i]) begin
                                r[i] <= Data;
                            end
                        end
                    end
                end
                S1: tmp <= r[sel_a];
                S2: r[sel_a] <= r[sel_b];
                S3: r[sel_b] <= tmp;
                C1: r[sel_b] <= r[sel_a];
                default: ;
            endcase
        end
    end

    // Bus source follows the current transfer; reset forces it low
    always_comb begin
        BusWires = '0;
        unique case (state)
            IDLE:    BusWires = Extern ? Data : '0;
            S1:      BusWires = r[sel_a];
            S2:      BusWires = r[sel_b];
            S3:      BusWires = tmp;
            C1:      BusWires = r[sel_a];
            default: BusWires = '0;
        endcase
        if (Reset) begin
            BusWires = '0;
        end
    end

    // Flatten the register bank for downstream readers
    always_comb begin
        RegOut = '0;
        for (int i = 0; i < NREGS; i++) begin
            RegOut[i*WIDTH +: WIDTH] = r[i];
        end
    end

endmodule

// File: tb/tb_swap_xbar.sv
// tb_swap_xbar: directed vectors for swap_xbar at 8x4 and 16x6.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_swap_xbar;

    logic Clock = 1'b0;
    logic Reset;

    always #5 Clock = ~Clock;

    logic [7:0]  a_data;
    logic        a_ext;
    logic [3:0]  a_rin;
    logic        a_w;
    logic        a_mode;
    logic [1:0]  a_sa;
    logic [1:0]  a_sb;
    logic [7:0]  a_bus;
    logic [31:0] a_reg;
    logic        a_busy;
    logic        a_done;

    logic [15:0] b_data;
    logic        b_ext;
    logic [5:0]  b_rin;
    logic        b_w;
    logic        b_mode;
    logic [2:0]  b_sa;
    logic [2:0]  b_sb;
    logic [15:0] b_bus;
    logic [95:0] b_reg;
    logic        b_busy;
    logic        b_done;

    int checks   = 0;
    int failures = 0;

    swap_xbar dut4 (
        .Clock(Clock), .Reset(Reset), .Data(a_data), .Extern(a_ext),
        .RinExt(a_rin), .w(a_w), .Mode(a_mode), .SelA(a_sa), .SelB(a_sb),
        .BusWires(a_bus), .RegOut(a_reg), .Busy(a_busy), .Done(a_done)
    );

    swap_xbar #(.WIDTH(16), .NREGS(6)) dut6 (
        .Clock(Clock), .Reset(Reset), .Data(b_data), .Extern(b_ext),
        .RinExt(b_rin), .w(b_w), .Mode(b_mode), .SelA(b_sa), .SelB(b_sb),
        .BusWires(b_bus), .RegOut(b_reg), .Busy(b_busy), .Done(b_done)
    );

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    logic [7:0] vals [4];

    initial begin
        vals[0] = 8'hCA; vals[1] = 8'hFE; vals[2] = 8'hBA; vals[3] = 8'hBE;
        Reset = 1'b1;
        a_data = '0; a_ext = 0; a_rin = '0; a_w = 0; a_mode = 0;
        a_sa = '0; a_sb = '0;
        b_data = '0; b_ext = 0; b_rin = '0; b_w = 0; b_mode = 0;
        b_sa = '0; b_sb = '0;
        #1;
        chk("rst_reg", a_reg, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_bus", a_bus, 0);
        tick();
        tick();
        Reset = 1'b0;

        // individual external loads
        for (int i = 0; i < 4; i++) begin
            a_ext = 1; a_rin = 4'(1 << i); a_data = vals[i];
            tick();
        end
        a_ext = 0; a_rin = '0;
        chk("load_reg", a_reg, 32'hBEBAFECA);
        chk("load_busy", a_busy, 0);

        // swap R0 <-> R1
        a_sa = 0; a_sb = 1; a_mode = 0; a_w = 1;
        tick();
        a_w = 0;
        chk("sw_s1_bus", a_bus, 8'hCA);
        chk("sw_s1_done", a_done, 0);
        chk("sw_s1_busy", a_busy, 1);
        tick();
        chk("sw_s2_bus", a_bus, 8'hFE);
        chk("sw_s2_done", a_done, 0);
        tick();
        chk("sw_s3_bus", a_bus, 8'hCA);
        chk("sw_s3_done", a_done, 1);
        tick();
        chk("sw_reg", a_reg, 32'hBEBACAFE);
        chk("sw_busy", a_busy, 0);
        chk("sw_done", a_done, 0);

        // copy R3 -> R2, external load attempted while busy
        a_sa = 3; a_sb = 2; a_mode = 1; a_w = 1;
        tick();
        a_w = 0;
        a_ext = 1; a_rin = 4'hF; a_data = 8'h55;
        chk("cp_done", a_done, 1);
        chk("cp_busy", a_busy, 1);
        chk("cp_bus", a_bus, 8'hBE);
        tick();
        a_ext = 0; a_rin = '0;
        chk("cp_reg", a_reg, 32'hBEBECAFE);
        chk("cp_done_off", a_done, 0);
        chk("cp_busy_off", a_busy, 0);

        // self swap with w held: Done every 4 cycles, contents stable
        a_sa = 2; a_sb = 2; a_mode = 0; a_w = 1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk($sformatf("hold_done%0d", i), a_done, (i % 4) == 3);
            chk($sformatf("hold_reg%0d", i), a_reg, 32'hBEBECAFE);
        end
        a_w = 0;
        tick();
        chk("hold_s3_done", a_done, 1);
        tick();
        chk("hold_end_reg", a_reg, 32'hBEBECAFE);
        chk("hold_end_busy", a_busy, 0);

        // reset in S2 of a 0 <-> 3 swap
        a_sa = 0; a_sb = 3; a_mode = 0; a_w = 1;
        tick();
        a_w = 0;
        tick();
        chk("ar_s2_bus", a_bus, 8'hBE);
        #2;
        Reset = 1'b1;
        #1;
        chk("ar_reg", a_reg, 0);
        chk("ar_bus", a_bus, 0);
        chk("ar_busy", a_busy, 0);
        chk("ar_done", a_done, 0);
        tick();
        Reset = 1'b0;
        tick();
        chk("ar_idle_busy", a_busy, 0);
        a_ext = 1; a_rin = 4'b0001; a_data = 8'h77;
        tick();
        a_ext = 0; a_rin = '0;
        chk("ar_idle_load", a_reg, 32'h00000077);

        // 16-bit, 6 register instance
        b_ext = 1; b_rin = 6'b100000; b_data = 16'h1234;
        tick();
        b_rin = 6'b000001; b_data = 16'hABCD;
        tick();
        b_ext = 0; b_rin = '0;
        chk("b_load", b_reg, {16'h1234, 64'h0, 16'hABCD});
        b_sa = 0; b_sb = 5; b_mode = 0; b_w = 1;
        tick();
        b_w = 0;
        chk("b_s1_bus", b_bus, 16'hABCD);
        tick();
        tick();
        chk("b_s3_done", b_done, 1);
        tick();
        chk("b_swap", b_reg, {16'hABCD, 64'h0, 16'h1234});
        b_sa = 7; b_sb = 1; b_w = 1;
        tick();
        chk("b_bad_busy", b_busy, 0);
        chk("b_bad_done", b_done, 0);
        tick();
        b_w = 0;
        chk("b_bad_busy2", b_busy, 0);
        chk("b_bad_reg", b_reg, {16'hABCD, 64'h0, 16'h1234});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/swap_xbar.md
# swap_xbar

Parametrised register-swap unit for the Crossbar datapath: NREGS registers of WIDTH bits on a shared bus, loaded externally and rearranged by an FSM-driven swap or copy between any two registers through a hidden temp register. It generalises the fixed three-register, hard-wired swap to arbitrary width, register count and operand selection, and adds a copy mode. It sits between the external data source and the downstream crossbar stages, which read the register contents directly.

## Interface
- WIDTH, 8, register and bus width in bits (≥1)
- NREGS, 4, number of user registers (≥2); SW = $clog2(NREGS)

- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high; clears all state
- Data  in  WIDTH  external load data
- Extern  in  1  enables external load in IDLE
- RinExt  in  NREGS  per-register load enables for external load (bit i → R[i])
- w  in  1  start request, sampled in IDLE
- Mode  in  1  0 = swap R[SelA]↔R[SelB], 1 = copy R[SelA]→R[SelB]
- SelA, SelB  in  SW  operand register indices
- BusWires  out  WIDTH  current bus value
- RegOut  out  NREGS*WIDTH  flat register contents, R[i] at bits [i*WIDTH +: WIDTH]
- Busy  out  1  high in any non-IDLE state
- Done  out  1  high during the final transfer state of an operation

## Operation
- States: IDLE, S1, S2, S3 (swap); C1 (copy).
- IDLE: if Extern=1, every R[i] with RinExt[i]=1 loads Data at the clock edge; several bits may be set at once. BusWires = Data when Extern=1, else 0.
- IDLE with w=1: latch SelA, SelB and Mode. Mode=0 → S1; Mode=1 → C1. If Extern=1 and w=1 arrive together, the external load happens and the operation also starts. Operands then use the post-load values.
- S1: Tmp ← R[A]; BusWires = R[A].
- S2: R[A] ← R[B]; BusWires = R[B].
- S3: R[B] ← Tmp; BusWires = Tmp; Done=1. Next state is IDLE.
- C1: R[B] ← R[A]; BusWires = R[A]; Done=1. Next state is IDLE.
- Outside IDLE, Extern, RinExt, w, Mode, SelA and SelB are ignored. The latched selections hold for the whole operation.
- SelA = SelB: the operation runs its full length and the register contents are unchanged.
- Selection index ≥ NREGS (non-power-of-two NREGS): the request is ignored, the FSM stays in IDLE and Done stays 0.
- Tmp is not visible on RegOut.

## Timing
- Reset asserted: asynchronously, all R[i]=0, Tmp=0, state=IDLE, Busy=0, Done=0, BusWires=0. Reset mid-operation aborts the operation; no partial result is retained.
- Swap: w sampled high at edge k → S1 during cycle k..k+1, S2 during k+1..k+2, S3 during k+2..k+3 with Done=1. Final contents are on RegOut after edge k+3, and Busy=1 for 3 cycles.
- Copy: w sampled at edge k → C1 during k..k+1 with Done=1. Result is valid after edge k+1, and Busy=1 for 1 cycle.
- Done and Busy are Moore outputs, decoded from state only.
- w held high continuously: after the final state there is one IDLE cycle, then w is re-sampled. Back-to-back swaps therefore have a 4-cycle period and back-to-back copies a 2-cycle period.
- External loads take effect at the edge on which they are sampled, with no added latency.

## Test plan
- Reset, then load R0..R3 = CA, FE, BA, BE via RinExt = 0001, 0010, 0100, 1000 with Extern=1 → RegOut = {BE,BA,FE,CA}, Busy=0.
- Swap with SelA=0, SelB=1, Mode=0, w pulse → BusWires shows CA, FE, CA on consecutive cycles. Done is high only in the 3rd cycle. Final R0=FE, R1=CA, R2=BA, R3=BE.
- Copy with SelA=3, SelB=2, Mode=1 → Done is high for 1 cycle and R2=BE. Then drive Extern=1, RinExt=1111, Data=55 while Busy=1 → no register changes.
- Swap with SelA=SelB=2, w held high for 10 cycles → Done pulses every 4 cycles and contents are unchanged throughout.
- Assert Reset during S2 of a 0↔3 swap → all registers, BusWires, Busy and Done go to 0 immediately, without waiting for a clock edge. After release, the FSM is in IDLE.
- Re-instantiate with WIDTH=16, NREGS=6 and load 0x1234 into R5 and 0xABCD into R0, then swap 0↔5 → R0=1234, R5=ABCD. A request with SelA=7 is ignored, with Busy staying 0.
